// File: rtl/clock_defs_pkg.sv
// Shared encodings for the clock's mode FSM, display mux and notify arbiter.
// Values here must track the mode FSM and display mux decoders exactly.
package clock_defs_pkg;

  typedef enum logic [3:0] {
    MODE_INITIAL        = 4'd0,
    MODE_CLOCK          = 4'd1,
    MODE_SHOW_CLOCK     = 4'd2,
    MODE_CHANGE_MODE    = 4'd3,
    MODE_TIMER          = 4'd4,
    MODE_SHOW_TIMER     = 4'd5,
    MODE_ALARM          = 4'd6,
    MODE_SHOW_ALARM     = 4'd7,
    MODE_SHOW_STOPWATCH = 4'd8
  } mode_e;

  localparam logic [2:0] SRC_CLOCK     = 3'd0;
  localparam logic [2:0] SRC_TIMER     = 3'd1;
  localparam logic [2:0] SRC_ALARM     = 3'd2;
  localparam logic [2:0] SRC_STOPWATCH = 3'd3;
  localparam logic [2:0] SRC_INPUT     = 3'd4;
  localparam logic [2:0] SRC_ERR       = 3'd5;
  localparam logic [2:0] SRC_RING      = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ERR        = 2'd1,
    ST_RING_ALARM = 2'd2,
    ST_RING_TIMER = 2'd3
  } arb_state_e;

  function automatic logic is_ring(
    input arb_state_e s
  );
    return (s == ST_RING_ALARM) ||
           (s == ST_RING_TIMER);
  endfunction

  // Display source for a plain mode when no overlay owns the display.
  function automatic logic [2:0] mode_src(
    input logic [3:0] m
  );
    logic [2:0] src;
    src = SRC_CLOCK;
    case (m)
      MODE_SHOW_CLOCK:     src = SRC_CLOCK;
      MODE_SHOW_TIMER:     src = SRC_TIMER;
      MODE_SHOW_ALARM:     src = SRC_ALARM;
      MODE_SHOW_STOPWATCH: src = SRC_STOPWATCH;
      MODE_INITIAL,
      MODE_CLOCK,
      MODE_CHANGE_MODE,
      MODE_TIMER,
      MODE_ALARM:          src = SRC_INPUT;
      default:             src = SRC_CLOCK;
    endcase
    return src;
  endfunction

endpackage

// File: rtl/tick_hold_counter.sv
// Tick-driven hold counter with synchronous clear.
// done fires on the tick that completes a hold of term+1 ticks.
module tick_hold_counter #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             tick,
  input  logic [CNT_W-1:0] term,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // Clear wins over counting so a tick on the entry edge is not counted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && tick) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = en && tick && (cnt == term);

endmodule

// File: rtl/notify_arbiter.sv
// Owns display source select and buzzer: error overlay, alarm/timer rings,
// ring queuing and acknowledge.
module notify_arbiter
  import clock_defs_pkg::*;
#(
  parameter int ERR_TICKS  = 20,
  parameter int RING_TICKS = 300,
  parameter int CNT_W      = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [3:0] mode,
  input  logic       error,
  input  logic       alarm_hit,
  input  logic       timer_done,
  input  logic       esc_flag,
  output logic [2:0] disp_sel,
  output logic       buzzer,
  output logic       ring_active,
  output logic       esc_mask
);

  localparam logic [CNT_W-1:0] ERR_TERM  =
    CNT_W'(ERR_TICKS - 1);
  localparam logic [CNT_W-1:0] RING_TERM =
    CNT_W'(RING_TICKS - 1);

  arb_state_e state;
  arb_state_e nxt;
  logic       pend_alarm;
  logic       pend_timer;

  logic       entry;
  logic       restart;
  logic       ring_end;
  logic       set_pa;
  logic       set_pt;
  logic       clr_pa;
  logic       clr_pt;
  logic       pa_eff;
  logic       pt_eff;

  logic             hold_done;
  logic [CNT_W-1:0] hold_term;
  logic             hold_en;
  logic             hold_clr;

  assign hold_term = (state == ST_ERR) ? ERR_TERM : RING_TERM;
  assign hold_en   = (state != ST_IDLE);
  assign hold_clr  = entry || restart;

  tick_hold_counter #(
    .CNT_W (CNT_W)
  ) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (hold_clr),
    .en    (hold_en),
    .tick  (tick),
    .term  (hold_term),
    .done  (hold_done)
  );

  // Next-state decision: priority, preemption and ring queuing.
  always_comb begin
    nxt      = state;
    entry    = 1'b0;
    restart  = 1'b0;
    ring_end = 1'b0;
    set_pa   = 1'b0;
    set_pt   = 1'b0;
    clr_pa   = 1'b0;
    clr_pt   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (alarm_hit) begin
          nxt    = ST_RING_ALARM;
          entry  = 1'b1;
          set_pt = timer_done;
        end else if (timer_done) begin
          nxt   = ST_RING_TIMER;
          entry = 1'b1;
        end else if (error) begin
          nxt   = ST_ERR;
          entry = 1'b1;
        end
      end
      ST_ERR: begin
        if (alarm_hit) begin
          nxt    = ST_RING_ALARM;
          entry  = 1'b1;
          set_pt = timer_done;
        end else if (timer_done) begin
          nxt   = ST_RING_TIMER;
          entry = 1'b1;
        end else if (error) begin
          restart = 1'b1;
        end else if (hold_done) begin
          nxt   = ST_IDLE;
          entry = 1'b1;
        end
      end
      ST_RING_ALARM: begin
        set_pt   = timer_done;
        ring_end = esc_flag || hold_done;
      end
      ST_RING_TIMER: begin
        set_pa   = alarm_hit;
        ring_end = esc_flag || hold_done;
      end
      default: begin
        nxt   = ST_IDLE;
        entry = 1'b1;
      end
    endcase
    // A request arriving on the ending cycle is served straight away.
    pa_eff = pend_alarm || set_pa;
    pt_eff = pend_timer || set_pt;
    if (ring_end) begin
      entry = 1'b1;
      if (pa_eff) begin
        nxt    = ST_RING_ALARM;
        clr_pa = 1'b1;
      end else if (pt_eff) begin
        nxt    = ST_RING_TIMER;
        clr_pt = 1'b1;
      end else begin
        nxt = ST_IDLE;
      end
    end
  end

  // FSM state, pending bits and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pend_alarm <= 1'b0;
      pend_timer <= 1'b0;
      buzzer     <= 1'b0;
      disp_sel   <= SRC_INPUT;
    end else begin
      state      <= nxt;
      pend_alarm <= pa_eff && !clr_pa;
      pend_timer <= pt_eff && !clr_pt;
      if (is_ring(nxt)) begin
        if (entry) begin
          buzzer <= 1'b1;
        end else if (tick) begin
          buzzer <= ~buzzer;
        end
      end else begin
        buzzer <= 1'b0;
      end
      if (is_ring(state)) begin
        disp_sel <= SRC_RING;
      end else if (state == ST_ERR) begin
        disp_sel <= SRC_ERR;
      end else begin
        disp_sel <= mode_src(mode);
      end
    end
  end

  assign ring_active = is_ring(state);
  assign esc_mask    = is_ring(state);

endmodule

// File: tb/tb_notify_arbiter.sv
// Directed bench for notify_arbiter with short hold times.
// Tick pulses every 4th cycle; outputs sampled 1 time unit after posedge.
module tb_notify_arbiter;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic [3:0] mode;
  logic       error;
  logic       alarm_hit;
  logic       timer_done;
  logic       esc_flag;
  logic [2:0] disp_sel;
  logic       buzzer;
  logic       ring_active;
  logic       esc_mask;

  int n_cmp;
  int n_bad;
  int tph;
  int tick_total;

  notify_arbiter #(
    .ERR_TICKS  (3),
    .RING_TICKS (5),
    .CNT_W      (9)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .mode        (mode),
    .error       (error),
    .alarm_hit   (alarm_hit),
    .timer_done  (timer_done),
    .esc_flag    (esc_flag),
    .disp_sel    (disp_sel),
    .buzzer      (buzzer),
    .ring_active (ring_active),
    .esc_mask    (esc_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    tick = (tph == 3);
    if (tph == 3) tick_total++;
    tph = (tph + 1) % 4;
    @(posedge clk);
    #1;
    tick       = 1'b0;
    error      = 1'b0;
    alarm_hit  = 1'b0;
    timer_done = 1'b0;
    esc_flag   = 1'b0;
  endtask

  task automatic wait_ticks(input int target);
    int n;
    n = 0;
    while (tick_total < target && n < 100) begin
      cyc();
      n++;
    end
    n_cmp++;
    if (tick_total < target) begin
      n_bad++;
      $display("FAIL wait_ticks: got %0d ticks, need %0d",
               tick_total, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mode  = 4'd2;
    cyc();
    cyc();
    n_cmp++;
    if (disp_sel !== 3'd4) begin
      n_bad++;
      $display("FAIL reset_disp: got %0d need 4", disp_sel);
    end
    n_cmp++;
    if (buzzer !== 1'b0 || ring_active !== 1'b0 ||
        esc_mask !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outs: buz=%b ring=%b mask=%b need 0",
               buzzer, ring_active, esc_mask);
    end
    rst_n = 1'b1;
    cyc();
    n_cmp++;
    if (disp_sel !== 3'd0) begin
      n_bad++;
      $display("FAIL release_disp: got %0d need 0", disp_sel);
    end
    n_cmp++;
    if (buzzer !== 1'b0) begin
      n_bad++;
      $display("FAIL release_buz: got %b need 0", buzzer);
    end
  endtask

  task automatic test_error();
    int t0;
    int t1;
    mode = 4'd3;
    cyc();
    error = 1'b1;
    cyc();
    t0 = tick_total;
    cyc();
    n_cmp++;
    if (disp_sel !== 3'd5) begin
      n_bad++;
      $display("FAIL err_disp: got %0d need 5", disp_sel);
    end
    wait_ticks(t0 + 3);
    cyc();
    n_cmp++;
    if (disp_sel !== 3'd4) begin
      n_bad++;
      $display("FAIL err_end_disp: got %0d need 4", disp_sel);
    end
    error = 1'b1;
    cyc();
    t0 = tick_total;
    wait_ticks(t0 + 2);
    error = 1'b1;
    cyc();
    t1 = tick_total;
    wait_ticks(t1 + 2);
    cyc();
    n_cmp++;
    if (disp_sel !== 3'd5) begin
      n_bad++;
      $display("FAIL err_extend: got %0d need 5", disp_sel);
    end
    wait_ticks(t1 + 3);
    cyc();
    n_cmp++;
    if (disp_sel !== 3'd4) begin
      n_bad++;
      $display("FAIL err_extend_end: got %0d need 4", disp_sel);
    end
  endtask

  task automatic test_ring_timeout();
    int t0;
    logic exp_b;
    mode = 4'd2;
    alarm_hit = 1'b1;
    cyc();
    t0 = tick_total;
    n_cmp++;
    if (ring_active !== 1'b1 || esc_mask !== 1'b1 ||
        buzzer !== 1'b1) begin
      n_bad++;
      $display("FAIL ring_entry: ring=%b mask=%b buz=%b need 1",
               ring_active, esc_mask, buzzer);
    end
    cyc();
    n_cmp++;
    if (disp_sel !== 3'd6) begin
      n_bad++;
      $display("FAIL ring_disp: got %0d need 6", disp_sel);
    end
    for (int i = 1; i <= 4; i++) begin
      wait_ticks(t0 + i);
      exp_b = (i % 2 == 0);
      n_cmp++;
      if (buzzer !== exp_b || ring_active !== 1'b1) begin
        n_bad++;
        $display("FAIL ring_buz%0d: buz=%b ring=%b need %b 1",
                 i, buzzer, ring_active, exp_b);
      end
    end
    wait_ticks(t0 + 5);
    n_cmp++;
    if (ring_active !== 1'b0 || buzzer !== 1'b0) begin
      n_bad++;
      $display("FAIL ring_timeout: ring=%b buz=%b need 0 0",
               ring_active, buzzer);
    end
    cyc();
    n_cmp++;
    if (disp_sel !== 3'd0) begin
      n_bad++;
      $display("FAIL ring_after_disp: got %0d need 0", disp_sel);
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    int t1;
    int seen;
    mode = 4'd5;
    alarm_hit  = 1'b1;
    timer_done = 1'b1;
    cyc();
    t0 = tick_total;
    wait_ticks(t0 + 2);
    esc_flag = 1'b1;
    cyc();
    t1 = tick_total;
    n_cmp++;
    if (ring_active !== 1'b1 || esc_mask !== 1'b1 ||
        buzzer !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_timer_entry: ring=%b mask=%b buz=%b",
               ring_active, esc_mask, buzzer);
    end
    wait_ticks(t1 + 4);
    n_cmp++;
    if (ring_active !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_cnt_clear: ring=%b need 1", ring_active);
    end
    esc_flag = 1'b1;
    cyc();
    n_cmp++;
    if (ring_active !== 1'b0 || esc_mask !== 1'b0 ||
        buzzer !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_ack: ring=%b mask=%b buz=%b need 0",
               ring_active, esc_mask, buzzer);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (ring_active) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL b2b_no_pend: ring cycles=%0d need 0", seen);
    end
    n_cmp++;
    if (disp_sel !== 3'd1) begin
      n_bad++;
      $display("FAIL b2b_disp: got %0d need 1", disp_sel);
    end
  endtask

  task automatic test_err_preempt();
    int t0;
    int seen;
    mode = 4'd3;
    error = 1'b1;
    cyc();
    cyc();
    n_cmp++;
    if (disp_sel !== 3'd5) begin
      n_bad++;
      $display("FAIL pre_err_disp: got %0d need 5", disp_sel);
    end
    timer_done = 1'b1;
    cyc();
    t0 = tick_total;
    n_cmp++;
    if (ring_active !== 1'b1 || buzzer !== 1'b1) begin
      n_bad++;
      $display("FAIL preempt: ring=%b buz=%b need 1 1",
               ring_active, buzzer);
    end
    error = 1'b1;
    cyc();
    cyc();
    n_cmp++;
    if (disp_sel !== 3'd6 || ring_active !== 1'b1) begin
      n_bad++;
      $display("FAIL ring_ign_err: disp=%0d ring=%b need 6 1",
               disp_sel, ring_active);
    end
    wait_ticks(t0 + 4);
    n_cmp++;
    if (ring_active !== 1'b1) begin
      n_bad++;
      $display("FAIL preempt_hold: ring=%b need 1", ring_active);
    end
    wait_ticks(t0 + 5);
    n_cmp++;
    if (ring_active !== 1'b0 || buzzer !== 1'b0) begin
      n_bad++;
      $display("FAIL preempt_end: ring=%b buz=%b need 0 0",
               ring_active, buzzer);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (ring_active) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL preempt_no_pend: ring cycles=%0d need 0", seen);
    end
  endtask

  task automatic test_reset_mid_ring();
    int t0;
    int seen;
    mode = 4'd3;
    alarm_hit  = 1'b1;
    timer_done = 1'b1;
    cyc();
    t0 = tick_total;
    wait_ticks(t0 + 1);
    rst_n = 1'b0;
    cyc();
    n_cmp++;
    if (ring_active !== 1'b0 || buzzer !== 1'b0 ||
        disp_sel !== 3'd4) begin
      n_bad++;
      $display("FAIL mid_reset: ring=%b buz=%b disp=%0d need 0 0 4",
               ring_active, buzzer, disp_sel);
    end
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (ring_active || buzzer) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL mid_reset_pend: ring cycles=%0d need 0", seen);
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    tph        = 0;
    tick_total = 0;
    tick       = 1'b0;
    rst_n      = 1'b0;
    mode       = 4'd0;
    error      = 1'b0;
    alarm_hit  = 1'b0;
    timer_done = 1'b0;
    esc_flag   = 1'b0;
    test_reset();
    test_error();
    test_ring_timeout();
    test_back_to_back();
    test_err_preempt();
    test_reset_mid_ring();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
